// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: registered multi-mode immediate extender with a small result FIFO.
//
// Takes a raw immediate and a mode code from decode, forms the extended operand, and
// buffers it so execute-stage stalls never drop an immediate. Both sides use valid/ready.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   producer has an immediate
//   in_ready   block can accept (not full)
//   in_imm     raw immediate, IN_WIDTH bits
//   in_mode    00 sign, 01 zero, 10 upper, 11 branch (sign-extend then << 2)
//   out_valid  head result available (not empty)
//   out_ready  consumer takes the head result
//   out_data   extended operand at the FIFO head, 0 when empty
//   out_neg    sign bit of out_data, 0 when empty
//
// Optional feature, enabled by defining IMM_EXT_PERF_EN:
//   perf_count 32-bit wrapping count of accepted pushes
//   perf_stall 32-bit wrapping count of cycles with in_valid=1 and in_ready=0
//
// OUT_WIDTH must be at least IN_WIDTH+2; DEPTH must be a power of two, at least 2.

module imm_ext_pipe #(
    parameter int unsigned IN_WIDTH  = 16,
    parameter int unsigned OUT_WIDTH = 32,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_imm,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_neg
`ifdef IMM_EXT_PERF_EN
    ,
    output logic [31:0]          perf_count,
    output logic [31:0]          perf_stall
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned ExtW = OUT_WIDTH - IN_WIDTH;

    typedef enum logic [1:0] {
        ModeSign   = 2'b00,
        ModeZero   = 2'b01,
        ModeUpper  = 2'b10,
        ModeBranch = 2'b11
    } mode_e;

    logic [OUT_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      count_q, count_d;

    logic                 push;
    logic                 pop;
    logic [OUT_WIDTH-1:0] sext;
    logic [OUT_WIDTH-1:0] ext_data;

    // Extension datapath, evaluated on the incoming immediate.
    always_comb begin
        sext     = {{ExtW{in_imm[IN_WIDTH-1]}}, in_imm};
        ext_data = sext;
        case (mode_e'(in_mode))
            ModeSign:   ext_data = sext;
            ModeZero:   ext_data = {{ExtW{1'b0}}, in_imm};
            ModeUpper:  ext_data = {in_imm, {ExtW{1'b0}}};
            ModeBranch: ext_data = {sext[OUT_WIDTH-3:0], 2'b00};
            default:    ext_data = sext;
        endcase
    end

    // Flags come straight from the registered count, so a pop cannot raise in_ready
    // in the same cycle.
    assign in_ready  = (count_q != CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_neg   = out_data[OUT_WIDTH-1];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: empty entries are masked at the output.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_ptr_q] <= ext_data;
        end
    end

`ifdef IMM_EXT_PERF_EN
    logic [31:0] perf_count_q;
    logic [31:0] perf_stall_q;
    logic        stall;

    assign stall = in_valid && !in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_count_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push) begin
                perf_count_q <= perf_count_q + 32'd1;
            end
            if (stall) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_count = perf_count_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe (default parameters: 16 -> 32, DEPTH 2).
// Inputs are driven on the falling edge; a monitor samples 2 time units later and
// tracks every handshake against a scoreboard of model results.

module tb_imm_ext_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_neg;
`ifdef IMM_EXT_PERF_EN
    logic [31:0] perf_count;
    logic [31:0] perf_stall;
`endif

    int          errors;
    int          checks;
    logic [31:0] sb[$];
    logic [31:0] mon_exp;

    imm_ext_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_neg   (out_neg)
`ifdef IMM_EXT_PERF_EN
        ,
        .perf_count(perf_count),
        .perf_stall(perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ext_model(input logic [15:0] imm, input logic [1:0] mode);
        logic signed [31:0] s;
        s = $signed(imm);
        case (mode)
            2'd0:    return s;
            2'd1:    return {16'h0000, imm};
            2'd2:    return {imm, 16'h0000};
            default: return s * 4;
        endcase
    endfunction

    // Scoreboard monitor: compares each popped head against the oldest expected result.
    always begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_pop: got out_data=%h but no entry expected", out_data);
                end else begin
                    mon_exp = sb.pop_front();
                    if (out_data !== mon_exp || out_neg !== mon_exp[31]) begin
                        errors++;
                        $display("FAIL sb_pop: got data=%h neg=%b want data=%h neg=%b",
                                 out_data, out_neg, mon_exp, mon_exp[31]);
                    end
                end
            end
            if (in_valid === 1'b1 && in_ready === 1'b1) begin
                sb.push_back(ext_model(in_imm, in_mode));
            end
        end
    end

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_imm    = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'h0 || out_neg !== 1'b0) begin
            errors++;
            $display("FAIL reset: got valid=%b ready=%b data=%h neg=%b want 0 1 00000000 0",
                     out_valid, in_ready, out_data, out_neg);
        end
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic test_modes();
        logic [15:0] imms [4];
        logic [31:0] exps [4];
        imms = '{16'hFFFF, 16'hFFFF, 16'h1234, 16'h8001};
        exps = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000, 32'hFFFE0004};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_imm   = imms[i];
            in_mode  = 2'(i);
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_data !== exps[i] || out_neg !== exps[i][31]) begin
                errors++;
                $display("FAIL mode%0d: got valid=%b data=%h neg=%b want 1 %h %b",
                         i, out_valid, out_data, out_neg, exps[i], exps[i][31]);
            end
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_data !== 32'h0) begin
                errors++;
                $display("FAIL mode%0d_drain: got valid=%b data=%h want 0 00000000",
                         i, out_valid, out_data);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_imm    = 16'h0001;
        @(negedge clk);
        in_imm = 16'h0002;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_one_entry: got in_ready=%b want 1", in_ready);
        end
        @(negedge clk);
        in_imm = 16'h0003;
        checks++;
        if (in_ready !== 1'b0 || out_data !== 32'h1) begin
            errors++;
            $display("FAIL bp_full: got in_ready=%b data=%h want 0 00000001", in_ready, out_data);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h1) begin
            errors++;
            $display("FAIL bp_hold: got in_ready=%b valid=%b data=%h want 0 1 00000001",
                     in_ready, out_valid, out_data);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_data !== 32'h2) begin
            errors++;
            $display("FAIL bp_first_pop: got in_ready=%b data=%h want 1 00000002",
                     in_ready, out_data);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h3) begin
            errors++;
            $display("FAIL bp_third: got valid=%b data=%h want 1 00000003", out_valid, out_data);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_streaming();
        logic [15:0] vals [8];
        logic [1:0]  modes [8];
        logic [31:0] e;
        for (int i = 0; i < 8; i++) begin
            vals[i]  = 16'(i * 16'h1111 + 16'h0F0F);
            modes[i] = 2'(i);
        end
        out_ready = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = ext_model(vals[i-1], modes[i-1]);
                checks++;
                if (out_valid !== 1'b1 || out_data !== e) begin
                    errors++;
                    $display("FAIL stream%0d: got valid=%b data=%h want 1 %h",
                             i - 1, out_valid, out_data, e);
                end
            end
            if (i < 8) begin
                in_valid = 1'b1;
                in_imm   = vals[i];
                in_mode  = modes[i];
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_empty: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] last_imm;
        logic [1:0]  last_mode;
        logic [31:0] e;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_imm    = 16'hA000;
        in_mode   = 2'd0;
        last_imm  = in_imm;
        last_mode = in_mode;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            e = ext_model(last_imm, last_mode);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data !== e) begin
                errors++;
                $display("FAIL simul%0d: got valid=%b ready=%b data=%h want 1 1 %h",
                         k, out_valid, in_ready, out_data, e);
            end
            out_ready = 1'b1;
            in_imm    = 16'(16'h7001 + k * 16'h2345);
            in_mode   = 2'(k + 1);
            last_imm  = in_imm;
            last_mode = in_mode;
        end
        @(negedge clk);
        in_valid = 1'b0;
        e = ext_model(last_imm, last_mode);
        checks++;
        if (out_valid !== 1'b1 || out_data !== e) begin
            errors++;
            $display("FAIL simul_last: got valid=%b data=%h want 1 %h", out_valid, out_data, e);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL simul_empty: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 2'd0;
        in_imm    = 16'h8888;
        @(negedge clk);
        in_imm = 16'h9999;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_full: got in_ready=%b valid=%b want 0 1", in_ready, out_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_neg !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset: got valid=%b data=%h neg=%b ready=%b want 0 00000000 0 1",
                     out_valid, out_data, out_neg, in_ready);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || out_data !== 32'h0) begin
                errors++;
                $display("FAIL mid_stale%0d: got valid=%b data=%h want 0 00000000",
                         k, out_valid, out_data);
            end
        end
    endtask

`ifdef IMM_EXT_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        out_ready = 1'b1;
        in_mode   = 2'd1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'(16'h0100 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_imm   = 16'(16'h0200 + i);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (perf_count !== 32'd5 || perf_stall !== 32'd3) begin
            errors++;
            $display("FAIL perf: got count=%0d stall=%0d want 5 3", perf_count, perf_stall);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        checks++;
        if (perf_count !== 32'd0 || perf_stall !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset: got count=%0d stall=%0d want 0 0", perf_count, perf_stall);
        end
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_modes();
        test_backpressure();
        test_streaming();
        test_simultaneous();
        test_reset_mid();
`ifdef IMM_EXT_PERF_EN
        test_perf();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending entries want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish within 100000 time units want finish");
        $fatal(1, "timeout");
    end

endmodule
